fust_scoreboard: RTL and testbench

Parametrised functional-unit status table and issue scoreboard for the tensor-core pipeline, sitting between dispatch and the scalar/matrix/GEMM execute units. It generalises the fixed scalar/matrix/GEMM status rows to NUM_FU identical rows. Each row has NUM_SRC source-operand tags, NUM_WB writeback broadcast ports, a per-row issue handshake, and speculative-row flush on branch mispredict.

---
 rtl/fust_scoreboard.sv | 189 ++++++++++++++++++
 tb/tb_fust_scoreboard.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fust_scoreboard.sv
// Functional-unit status table: one row per FU tracks a dispatched op from
// operand wait through issue and execution, with writeback tag clearing and mispredict flush.
module fust_scoreboard #(
   parameter int NUM_FU  = 5,
   parameter int NUM_SRC = 3,
   parameter int NUM_WB  = 2,
   parameter int REG_W   = 5,
   parameter int OP_W    = 4,
   localparam int FU_W   = $clog2(NUM_FU),
   localparam int TAG_W  = $clog2(NUM_FU + 1)
) (
   input  logic                             CLK,
   input  logic                             nRST,
   input  logic                             disp_en,
   input  logic [FU_W-1:0]                  disp_fu,
   input  logic [OP_W-1:0]                  disp_op,
   input  logic [REG_W-1:0]                 disp_rd,
   input  logic [NUM_SRC*REG_W-1:0]         disp_rs,
   input  logic [NUM_SRC*TAG_W-1:0]         disp_tag,
   input  logic                             disp_spec,
   output logic [NUM_FU-1:0]                disp_ready,
   output logic                             disp_err,
   input  logic [NUM_WB-1:0]                wb_valid,
   input  logic [NUM_WB*FU_W-1:0]           wb_fu,
   input  logic                             freeze,
   output logic [NUM_FU-1:0]                issue_valid,
   output logic [NUM_FU*OP_W-1:0]           issue_op,
   output logic [NUM_FU*REG_W-1:0]          issue_rd,
   output logic [NUM_FU*NUM_SRC*REG_W-1:0]  issue_rs,
   input  logic [NUM_FU-1:0]                fu_ack,
   input  logic [NUM_FU-1:0]                fu_done,
   input  logic                             branch_resolved,
   input  logic                             branch_miss,
   output logic [NUM_FU*2-1:0]              row_state
);

   typedef enum logic [1:0] {
      ST_FREE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_READY = 2'd2,
      ST_EXEC  = 2'd3
   } row_st_e;

   row_st_e                    state_q [NUM_FU];
   row_st_e                    state_d [NUM_FU];
   logic [TAG_W-1:0]           tag_q   [NUM_FU][NUM_SRC];
   logic [TAG_W-1:0]           tag_d   [NUM_FU][NUM_SRC];
   logic [OP_W-1:0]            op_q    [NUM_FU];
   logic [OP_W-1:0]            op_d    [NUM_FU];
   logic [REG_W-1:0]           rd_q    [NUM_FU];
   logic [REG_W-1:0]           rd_d    [NUM_FU];
   logic [NUM_SRC*REG_W-1:0]   rs_q    [NUM_FU];
   logic [NUM_SRC*REG_W-1:0]   rs_d    [NUM_FU];
   logic [NUM_FU-1:0]          spec_q;
   logic [NUM_FU-1:0]          spec_d;
   logic                       disp_err_q;
   logic                       disp_err_d;

   logic                       flush_c;
   logic                       drop_c;
   logic [NUM_FU-1:0]          disp_sel_c;
   logic [NUM_FU-1:0]          row_free_c;
   logic [NUM_FU-1:0]          row_clear_c;
   logic [TAG_W-1:0]           dtag_c  [NUM_SRC];
   logic                       disp_zero_c;

   // A tag of k names FU k-1; tag 0 never matches since it means "available".
   function automatic logic tag_hit(input logic [TAG_W-1:0]       tag,
                                    input logic [NUM_WB-1:0]      vld,
                                    input logic [NUM_WB*FU_W-1:0] fu);
      logic hit;
      hit = 1'b0;
      for (int j = 0; j < NUM_WB; j++) begin
         if (vld[j] && (tag != '0) &&
             (tag == TAG_W'(fu[j*FU_W +: FU_W]) + TAG_W'(1))) begin
            hit = 1'b1;
         end
      end
      return hit;
   endfunction

   always_comb begin
      disp_ready  = '0;
      issue_valid = '0;
      issue_op    = '0;
      issue_rd    = '0;
      issue_rs    = '0;
      row_state   = '0;
      for (int i = 0; i < NUM_FU; i++) begin
         disp_ready[i]                                  = (state_q[i] == ST_FREE);
         issue_valid[i]                                 = (state_q[i] == ST_READY) && !freeze;
         issue_op[i*OP_W +: OP_W]                       = op_q[i];
         issue_rd[i*REG_W +: REG_W]                     = rd_q[i];
         issue_rs[i*NUM_SRC*REG_W +: NUM_SRC*REG_W]     = rs_q[i];
         row_state[i*2 +: 2]                            = state_q[i];
      end
      disp_err = disp_err_q;
   end

   // Dispatch decode; an out-of-range disp_fu selects no row and so errors.
   always_comb begin
      flush_c     = branch_resolved && branch_miss;
      drop_c      = disp_en && disp_spec && flush_c;
      disp_sel_c  = '0;
      row_free_c  = '0;
      for (int i = 0; i < NUM_FU; i++) begin
         disp_sel_c[i] = disp_en && (disp_fu == FU_W'(i));
         row_free_c[i] = (state_q[i] == ST_FREE);
      end
      disp_err_d  = disp_en && !drop_c && ((disp_sel_c & row_free_c) == '0);
      disp_zero_c = 1'b1;
      for (int s = 0; s < NUM_SRC; s++) begin
         dtag_c[s] = disp_tag[s*TAG_W +: TAG_W];
         if (tag_hit(dtag_c[s], wb_valid, wb_fu)) begin
            dtag_c[s] = '0;
         end
         if (dtag_c[s] != '0) begin
            disp_zero_c = 1'b0;
         end
      end
   end

   always_comb begin
      spec_d      = spec_q;
      row_clear_c = '1;
      for (int i = 0; i < NUM_FU; i++) begin
         state_d[i] = state_q[i];
         op_d[i]    = op_q[i];
         rd_d[i]    = rd_q[i];
         rs_d[i]    = rs_q[i];
         for (int s = 0; s < NUM_SRC; s++) begin
            tag_d[i][s] = tag_hit(tag_q[i][s], wb_valid, wb_fu) ? '0 : tag_q[i][s];
            if (tag_d[i][s] != '0) begin
               row_clear_c[i] = 1'b0;
            end
         end
         if (branch_resolved && !branch_miss) begin
            spec_d[i] = 1'b0;
         end

         // Per-row precedence: flush, completion, issue, operand wakeup, dispatch.
         if (flush_c && spec_q[i]) begin
            state_d[i] = ST_FREE;
            spec_d[i]  = 1'b0;
         end else if ((state_q[i] == ST_EXEC) && fu_done[i]) begin
            state_d[i] = ST_FREE;
            spec_d[i]  = 1'b0;
         end else if ((state_q[i] == ST_READY) && issue_valid[i] && fu_ack[i]) begin
            state_d[i] = ST_EXEC;
         end else if ((state_q[i] == ST_WAIT) && row_clear_c[i]) begin
            state_d[i] = ST_READY;
         end else if (disp_sel_c[i] && row_free_c[i] && !drop_c) begin
            state_d[i] = disp_zero_c ? ST_READY : ST_WAIT;
            op_d[i]    = disp_op;
            rd_d[i]    = disp_rd;
            rs_d[i]    = disp_rs;
            spec_d[i]  = disp_spec && !branch_resolved;
            for (int s = 0; s < NUM_SRC; s++) begin
               tag_d[i][s] = dtag_c[s];
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < NUM_FU; i++) begin
            state_q[i] <= ST_FREE;
            op_q[i]    <= '0;
            rd_q[i]    <= '0;
            rs_q[i]    <= '0;
            for (int s = 0; s < NUM_SRC; s++) begin
               tag_q[i][s] <= '0;
            end
         end
         spec_q     <= '0;
         disp_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         rd_q       <= rd_d;
         rs_q       <= rs_d;
         tag_q      <= tag_d;
         spec_q     <= spec_d;
         disp_err_q <= disp_err_d;
      end
   end

endmodule

// File: tb/tb_fust_scoreboard.sv
// Directed bench for fust_scoreboard: dispatch, wakeup, bypass, freeze, flush,
// dispatch errors and asynchronous reset, with hand-computed expectations.
module tb_fust_scoreboard;

   logic        CLK;
   logic        nRST;
   logic        disp_en;
   logic [2:0]  disp_fu;
   logic [3:0]  disp_op;
   logic [4:0]  disp_rd;
   logic [14:0] disp_rs;
   logic [8:0]  disp_tag;
   logic        disp_spec;
   logic [4:0]  disp_ready;
   logic        disp_err;
   logic [1:0]  wb_valid;
   logic [5:0]  wb_fu;
   logic        freeze;
   logic [4:0]  issue_valid;
   logic [19:0] issue_op;
   logic [24:0] issue_rd;
   logic [74:0] issue_rs;
   logic [4:0]  fu_ack;
   logic [4:0]  fu_done;
   logic        branch_resolved;
   logic        branch_miss;
   logic [9:0]  row_state;

   int n_cmp = 0;
   int n_err = 0;

   fust_scoreboard dut (
      .CLK             (CLK),
      .nRST            (nRST),
      .disp_en         (disp_en),
      .disp_fu         (disp_fu),
      .disp_op         (disp_op),
      .disp_rd         (disp_rd),
      .disp_rs         (disp_rs),
      .disp_tag        (disp_tag),
      .disp_spec       (disp_spec),
      .disp_ready      (disp_ready),
      .disp_err        (disp_err),
      .wb_valid        (wb_valid),
      .wb_fu           (wb_fu),
      .freeze          (freeze),
      .issue_valid     (issue_valid),
      .issue_op        (issue_op),
      .issue_rd        (issue_rd),
      .issue_rs        (issue_rs),
      .fu_ack          (fu_ack),
      .fu_done         (fu_done),
      .branch_resolved (branch_resolved),
      .branch_miss     (branch_miss),
      .row_state       (row_state)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      disp_en         = 1'b0;
      disp_fu         = '0;
      disp_op         = '0;
      disp_rd         = '0;
      disp_rs         = '0;
      disp_tag        = '0;
      disp_spec       = 1'b0;
      wb_valid        = '0;
      wb_fu           = '0;
      fu_ack          = '0;
      fu_done         = '0;
      branch_resolved = 1'b0;
      branch_miss     = 1'b0;
   endtask

   task automatic clk_edge();
      @(posedge CLK);
      #1;
      idle();
      #1;
   endtask

   task automatic drive_disp(input int fu, input int op, input int rd,
                             input int r0, input int r1, input int r2,
                             input int t0, input int t1, input int t2,
                             input logic spec);
      disp_en   = 1'b1;
      disp_fu   = 3'(fu);
      disp_op   = 4'(op);
      disp_rd   = 5'(rd);
      disp_rs   = {5'(r2), 5'(r1), 5'(r0)};
      disp_tag  = {3'(t2), 3'(t1), 3'(t0)};
      disp_spec = spec;
   endtask

   initial begin
      nRST   = 1'b0;
      freeze = 1'b0;
      idle();
      @(posedge CLK);
      @(posedge CLK);
      #1;
      check("rst_state", 64'(row_state), 64'h0);
      check("rst_ready", 64'(disp_ready), 64'h1f);
      check("rst_issue", 64'(issue_valid), 64'h0);
      check("rst_err", 64'(disp_err), 64'h0);
      nRST = 1'b1;

      // Basic dispatch -> issue -> exec -> free on row 2
      drive_disp(2, 3, 7, 1, 2, 0, 0, 0, 0, 1'b0);
      clk_edge();
      check("t1_state", 64'(row_state), 64'h020);
      check("t1_issue", 64'(issue_valid), 64'h04);
      check("t1_rd", 64'(issue_rd[10 +: 5]), 64'h7);
      check("t1_op", 64'(issue_op[8 +: 4]), 64'h3);
      check("t1_rs", 64'(issue_rs[30 +: 15]), 64'h41);
      check("t1_ready", 64'(disp_ready), 64'h1b);
      fu_ack = 5'b00100;
      clk_edge();
      check("t1_exec", 64'(row_state), 64'h030);
      check("t1_issue_drop", 64'(issue_valid), 64'h0);
      fu_done = 5'b00100;
      clk_edge();
      check("t1_free", 64'(row_state), 64'h0);
      check("t1_ready2", 64'(disp_ready), 64'h1f);

      // Tag wakeup on row 0: tags {2,4,0}
      drive_disp(0, 5, 3, 4, 5, 6, 2, 4, 0, 1'b0);
      clk_edge();
      check("t2_wait", 64'(row_state), 64'h1);
      check("t2_issue0", 64'(issue_valid), 64'h0);
      wb_valid = 2'b01;
      wb_fu    = {3'd0, 3'd1};
      clk_edge();
      check("t2_still_wait", 64'(row_state), 64'h1);
      wb_valid = 2'b10;
      wb_fu    = {3'd3, 3'd0};
      clk_edge();
      check("t2_ready", 64'(row_state), 64'h2);
      check("t2_issue", 64'(issue_valid), 64'h01);
      fu_ack = 5'b00001;
      clk_edge();
      fu_done = 5'b00001;
      clk_edge();
      check("t2_free", 64'(row_state), 64'h0);

      // Same-cycle writeback bypass on dispatch
      drive_disp(0, 1, 2, 0, 0, 0, 1, 0, 0, 1'b0);
      wb_valid = 2'b01;
      wb_fu    = {3'd0, 3'd0};
      clk_edge();
      check("t3_bypass", 64'(row_state), 64'h2);
      check("t3_issue", 64'(issue_valid), 64'h01);
      fu_ack = 5'b00001;
      clk_edge();
      fu_done = 5'b00001;
      clk_edge();

      // Freeze holds off issue on row 1, even with fu_ack asserted
      freeze = 1'b1;
      drive_disp(1, 2, 4, 0, 0, 0, 0, 0, 0, 1'b0);
      clk_edge();
      check("t4_frz0", 64'(issue_valid), 64'h0);
      for (int c = 0; c < 2; c++) begin
         fu_ack = 5'b00010;
         clk_edge();
         check("t4_frz_iv", 64'(issue_valid), 64'h0);
         check("t4_frz_st", 64'(row_state), 64'h8);
      end
      freeze = 1'b0;
      #1;
      check("t4_unfrz", 64'(issue_valid), 64'h02);
      fu_ack = 5'b00010;
      clk_edge();
      fu_done = 5'b00010;
      clk_edge();

      // Mispredict flush: row1 spec EXEC, row3 spec WAIT, row4 non-spec READY
      drive_disp(1, 9, 10, 0, 0, 0, 0, 0, 0, 1'b1);
      clk_edge();
      fu_ack = 5'b00010;
      clk_edge();
      drive_disp(3, 8, 11, 0, 0, 0, 5, 0, 0, 1'b1);
      clk_edge();
      drive_disp(4, 7, 12, 0, 0, 0, 0, 0, 0, 1'b0);
      clk_edge();
      check("t5_pre", 64'(row_state), 64'h24c);
      branch_resolved = 1'b1;
      branch_miss     = 1'b1;
      clk_edge();
      check("t5_flush", 64'(row_state), 64'h200);
      fu_done = 5'b00010;
      clk_edge();
      check("t5_done_ign", 64'(row_state), 64'h200);
      check("t5_ready", 64'(disp_ready), 64'h0f);

      // Correct resolve clears spec so a later miss leaves the row alone
      drive_disp(0, 4, 13, 0, 0, 0, 0, 0, 0, 1'b1);
      clk_edge();
      branch_resolved = 1'b1;
      clk_edge();
      branch_resolved = 1'b1;
      branch_miss     = 1'b1;
      clk_edge();
      check("t5_resolved", 64'(row_state), 64'h202);

      // Spec dispatch colliding with a miss is dropped silently
      drive_disp(2, 4, 14, 0, 0, 0, 0, 0, 0, 1'b1);
      branch_resolved = 1'b1;
      branch_miss     = 1'b1;
      clk_edge();
      check("t5_drop", 64'(row_state), 64'h202);
      check("t5_drop_err", 64'(disp_err), 64'h0);

      // Spec dispatch with a correct resolve is stored as non-spec
      drive_disp(2, 4, 14, 0, 0, 0, 0, 0, 0, 1'b1);
      branch_resolved = 1'b1;
      clk_edge();
      branch_resolved = 1'b1;
      branch_miss     = 1'b1;
      clk_edge();
      check("t5_keep", 64'(row_state), 64'h222);

      // Dispatch to busy row 3 and to an out-of-range row
      drive_disp(3, 6, 9, 0, 0, 0, 5, 0, 0, 1'b0);
      clk_edge();
      check("t6_wait", 64'(row_state), 64'h262);
      drive_disp(3, 1, 1, 0, 0, 0, 0, 0, 0, 1'b0);
      clk_edge();
      check("t6_err", 64'(disp_err), 64'h1);
      check("t6_state", 64'(row_state), 64'h262);
      check("t6_rd", 64'(issue_rd[15 +: 5]), 64'h9);
      check("t6_op", 64'(issue_op[12 +: 4]), 64'h6);
      clk_edge();
      check("t6_err_clr", 64'(disp_err), 64'h0);
      drive_disp(7, 1, 1, 0, 0, 0, 0, 0, 0, 1'b0);
      clk_edge();
      check("t6_range_err", 64'(disp_err), 64'h1);
      check("t6_range_st", 64'(row_state), 64'h262);

      // Asynchronous reset while rows are busy
      #2;
      nRST = 1'b0;
      #1;
      check("t7_state", 64'(row_state), 64'h0);
      check("t7_issue", 64'(issue_valid), 64'h0);
      check("t7_ready", 64'(disp_ready), 64'h1f);
      check("t7_err", 64'(disp_err), 64'h0);
      @(posedge CLK);
      #1;
      nRST = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
